// File: rtl/cpu_vector_imem.sv
// Instruction memory for the vector CPU fetch stage, loaded at boot from a byte stream.
// Optional stored-parity checking is enabled by defining IMEM_PARITY_EN.
module cpu_vector_imem #(
    parameter int          ADDR_W   = 8,
    parameter logic [29:0] NOP_WORD = 30'h1C000000,
    parameter bit          BOOT_RUN = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    output logic [29:0] instr,
    output logic        instr_valid,
    input  logic        ld_start,
    input  logic        ld_valid,
    input  logic [7:0]  ld_data,
    input  logic        ld_last,
    output logic        ld_ready,
    output logic        ld_done,
    output logic        ld_err,
    output logic        par_err,
    output logic [1:0]  dbg_state
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          byte_cnt_q, byte_cnt_d;
    logic [ADDR_W:0]     word_cnt_q, word_cnt_d;
    logic [23:0]         word_buf_q, word_buf_d;
    logic                ld_err_q, ld_err_d;
    logic                ld_done_q, ld_done_d;
    logic [29:0]         instr_q, instr_d;
    logic                instr_valid_q, instr_valid_d;
    logic                par_err_q, par_err_d;

    logic [29:0]         mem_q [DEPTH];
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [29:0]         asm_word;
    logic [23:0]         buf_next;
    logic                accept;
    logic [ADDR_W-1:0]   pc_idx;
    logic                pc_oob;
    logic                unused_pc_bits;

`ifdef IMEM_PARITY_EN
    logic                mem_par_q [DEPTH];
`endif

    assign pc_idx         = pc[ADDR_W+1:2];
    assign pc_oob         = |pc[31:ADDR_W+2];
    assign unused_pc_bits = ^pc[1:0];
    assign accept         = (state_q == S_LOAD) && ld_valid;
    assign mem_waddr      = word_cnt_q[ADDR_W-1:0];

    // Bytes not yet received stay zero, so a short final word is zero-padded.
    always_comb begin
        buf_next = word_buf_q;
        case (byte_cnt_q)
            2'd0:    buf_next[7:0]   = ld_data;
            2'd1:    buf_next[15:8]  = ld_data;
            2'd2:    buf_next[23:16] = ld_data;
            default: buf_next        = word_buf_q;
        endcase
        asm_word = {(byte_cnt_q == 2'd3) ? ld_data[5:0] : 6'd0, buf_next};
    end

    always_comb begin
        state_d       = state_q;
        byte_cnt_d    = byte_cnt_q;
        word_cnt_d    = word_cnt_q;
        word_buf_d    = word_buf_q;
        ld_err_d      = ld_err_q;
        ld_done_d     = 1'b0;
        instr_d       = NOP_WORD;
        instr_valid_d = 1'b0;
        par_err_d     = 1'b0;
        mem_we        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (ld_start) begin
                    state_d    = S_LOAD;
                    byte_cnt_d = 2'd0;
                    word_cnt_d = '0;
                    word_buf_d = '0;
                    ld_err_d   = 1'b0;
                end
            end
            S_LOAD: begin
                if (accept) begin
                    word_buf_d = buf_next;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3 || ld_last) begin
                        word_buf_d = '0;
                        byte_cnt_d = 2'd0;
                        // word_cnt saturates at DEPTH; every later word is dropped.
                        if (word_cnt_q[ADDR_W]) begin
                            ld_err_d = 1'b1;
                        end else begin
                            mem_we     = 1'b1;
                            word_cnt_d = word_cnt_q + 1'b1;
                        end
                    end
                    if (ld_last) begin
                        state_d   = S_RUN;
                        ld_done_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (ld_start) begin
                    state_d    = S_LOAD;
                    byte_cnt_d = 2'd0;
                    word_cnt_d = '0;
                    word_buf_d = '0;
                    ld_err_d   = 1'b0;
                end else begin
                    instr_valid_d = 1'b1;
                    if (!pc_oob) begin
                        instr_d = mem_q[pc_idx];
`ifdef IMEM_PARITY_EN
                        par_err_d = mem_par_q[pc_idx] ^ (^mem_q[pc_idx]);
`endif
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= BOOT_RUN ? S_RUN : S_IDLE;
            byte_cnt_q    <= 2'd0;
            word_cnt_q    <= '0;
            word_buf_q    <= '0;
            ld_err_q      <= 1'b0;
            ld_done_q     <= 1'b0;
            instr_q       <= NOP_WORD;
            instr_valid_q <= 1'b0;
            par_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            byte_cnt_q    <= byte_cnt_d;
            word_cnt_q    <= word_cnt_d;
            word_buf_q    <= word_buf_d;
            ld_err_q      <= ld_err_d;
            ld_done_q     <= ld_done_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            par_err_q     <= par_err_d;
        end
    end

    // Memory is deliberately left out of reset so a reset keeps the program.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem_q[mem_waddr] <= asm_word;
`ifdef IMEM_PARITY_EN
            mem_par_q[mem_waddr] <= ^asm_word;
`endif
        end
    end

    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign ld_ready    = (state_q == S_LOAD);
    assign ld_done     = ld_done_q;
    assign ld_err      = ld_err_q;
    assign par_err     = par_err_q;
    assign dbg_state   = state_q;
endmodule

// File: tb/tb_cpu_vector_imem.sv
// Directed bench for cpu_vector_imem: a depth-256 instance and a depth-4 instance share stimulus.
module tb_cpu_vector_imem;
    localparam logic [29:0] NOP = 30'h1C000000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc = 32'd0;
    logic        ld_start = 1'b0;
    logic        ld_valid = 1'b0;
    logic [7:0]  ld_data = 8'd0;
    logic        ld_last = 1'b0;

    logic [29:0] instr, instr_s;
    logic        instr_valid, instr_valid_s;
    logic        ld_ready, ld_ready_s;
    logic        ld_done, ld_done_s;
    logic        ld_err, ld_err_s;
    logic        par_err, par_err_s;
    logic [1:0]  dbg_state, dbg_state_s;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    cpu_vector_imem #(.ADDR_W(8)) dut (
        .clk(clk), .rst(rst), .pc(pc), .instr(instr), .instr_valid(instr_valid),
        .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
        .ld_ready(ld_ready), .ld_done(ld_done), .ld_err(ld_err), .par_err(par_err),
        .dbg_state(dbg_state)
    );

    cpu_vector_imem #(.ADDR_W(2)) dut_s (
        .clk(clk), .rst(rst), .pc(pc), .instr(instr_s), .instr_valid(instr_valid_s),
        .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
        .ld_ready(ld_ready_s), .ld_done(ld_done_s), .ld_err(ld_err_s), .par_err(par_err_s),
        .dbg_state(dbg_state_s)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last);
        ld_valid = 1'b1;
        ld_data  = d;
        ld_last  = last;
        step();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic start_load();
        ld_start = 1'b1;
        step();
        ld_start = 1'b0;
    endtask

    task automatic fetch(input string tag, input logic [31:0] addr, input logic [29:0] exp);
        pc = addr;
        step();
        check({tag, "_instr"}, {2'b00, instr}, {2'b00, exp});
        check({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
    endtask

    initial begin
        // Reset
        step();
        step();
        rst = 1'b0;
        check("rst_instr", {2'b00, instr}, {2'b00, NOP});
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_ready", {31'd0, ld_ready}, 32'd0);
        check("rst_done", {31'd0, ld_done}, 32'd0);
        check("rst_err", {31'd0, ld_err}, 32'd0);
        check("rst_par", {31'd0, par_err}, 32'd0);
        check("rst_state", {30'd0, dbg_state}, 32'd0);

        // A byte offered in IDLE is not consumed and does not start anything
        send_byte(8'hAA, 1'b1);
        check("idle_state", {30'd0, dbg_state}, 32'd0);
        check("idle_done", {31'd0, ld_done}, 32'd0);

        // Single word load
        start_load();
        check("t1_ready", {31'd0, ld_ready}, 32'd1);
        check("t1_state", {30'd0, dbg_state}, 32'd1);
        send_byte(8'h0F, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h22, 1'b1);
        check("t1_done", {31'd0, ld_done}, 32'd1);
        check("t1_valid0", {31'd0, instr_valid}, 32'd0);
        check("t1_state_run", {30'd0, dbg_state}, 32'd2);
        check("t1_ready_run", {31'd0, ld_ready}, 32'd0);
        pc = 32'd0;
        step();
        check("t1_done_low", {31'd0, ld_done}, 32'd0);
        check("t1_instr", {2'b00, instr}, 32'h2200000F);
        check("t1_valid", {31'd0, instr_valid}, 32'd1);

        // Reload from RUN with two words
        start_load();
        check("t2_nop", {2'b00, instr}, {2'b00, NOP});
        check("t2_valid0", {31'd0, instr_valid}, 32'd0);
        check("t2_ready", {31'd0, ld_ready}, 32'd1);
        send_byte(8'h0A, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h03, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h11, 1'b1);
        check("t2_done", {31'd0, ld_done}, 32'd1);
        fetch("t2_pc0", 32'd0, 30'h2200000A);
        fetch("t2_pc4", 32'd4, 30'h11000003);
        fetch("t2_pc5", 32'd5, 30'h11000003);
        fetch("t2_oob", 32'h00010000, NOP);

        // Partial final word is zero-padded
        start_load();
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h03, 1'b0);
        send_byte(8'h04, 1'b0);
        ld_last = 1'b1;
        step();
        ld_last = 1'b0;
        check("t3_last_novalid", {30'd0, dbg_state}, 32'd1);
        send_byte(8'hFF, 1'b1);
        check("t3_err", {31'd0, ld_err}, 32'd0);
        fetch("t3_pc0", 32'd0, 30'h04030201);
        fetch("t3_pc4", 32'd4, 30'h000000FF);

        // Five words: depth-4 instance overflows, byte3[7:6] discarded
        start_load();
        for (int k = 0; k < 5; k++) begin
            send_byte(8'h30 + 8'(k), 1'b0);
            send_byte(8'h00, 1'b0);
            send_byte(8'h00, 1'b0);
            send_byte(8'hC5, k == 4);
        end
        check("t4_err_small", {31'd0, ld_err_s}, 32'd1);
        check("t4_done_small", {31'd0, ld_done_s}, 32'd1);
        check("t4_err_big", {31'd0, ld_err}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            pc = 32'(4 * k);
            step();
            check("t4_small_word", {2'b00, instr_s}, 32'h05000030 + 32'(k));
            check("t4_small_valid", {31'd0, instr_valid_s}, 32'd1);
        end
        pc = 32'd16;
        step();
        check("t4_small_oob", {2'b00, instr_s}, {2'b00, NOP});
        check("t4_small_oob_v", {31'd0, instr_valid_s}, 32'd1);
        check("t4_big_w4", {2'b00, instr}, 32'h05000034);

        // Reload then reset mid-load
        pc = 32'd0;
        start_load();
        check("t5_nop", {2'b00, instr}, {2'b00, NOP});
        check("t5_valid0", {31'd0, instr_valid}, 32'd0);
        check("t5_ready", {31'd0, ld_ready}, 32'd1);
        send_byte(8'h77, 1'b0);
        send_byte(8'h88, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t5_state", {30'd0, dbg_state}, 32'd0);
        check("t5_ready0", {31'd0, ld_ready}, 32'd0);
        check("t5_small_err", {31'd0, ld_err_s}, 32'd0);
        start_load();
        send_byte(8'h55, 1'b1);
        fetch("t5_pc0", 32'd0, 30'h00000055);
        fetch("t5_pc4", 32'd4, 30'h05000031);
        fetch("t5_pc8", 32'd8, 30'h05000032);
        check("t5_par", {31'd0, par_err}, 32'd0);

`ifdef IMEM_PARITY_EN
        dut.mem_q[1] = dut.mem_q[1] ^ 30'h1;
        pc = 32'd4;
        step();
        check("t6_par_err", {31'd0, par_err}, 32'd1);
        pc = 32'd8;
        step();
        check("t6_par_ok", {31'd0, par_err}, 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/cpu_vector_imem.md
Name: cpu_vector_imem

Overview:
- Instruction memory responder for the vector CPU fetch stage.
- Fetch drives `pc`. This block returns the 30-bit instruction word one cycle later, with a valid flag.
- Program contents are loaded at boot through a byte-stream loader port; the FSM keeps fetch supplied with NOPs until the load finishes.
- Sits between the program loader (host/UART bridge) and the fetch stage.

Parameters:
- ADDR_W, 8, word-address width; memory depth = 2**ADDR_W words of 30 bits.
- NOP_WORD, 30'h1C000000, instruction returned when not running or when the address is out of range (opcode 0111, rest zero).
- BOOT_RUN, 0, if 1 the FSM enters RUN directly after reset, without a load.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous active-high reset
- pc  input  32  byte address from fetch; word index = pc[ADDR_W+1:2], pc[1:0] ignored
- instr  output  30  registered instruction for the previous cycle's pc
- instr_valid  output  1  instr holds a real memory word
- ld_start  input  1  one-cycle pulse; begin (re)load
- ld_valid  input  1  loader byte present
- ld_data  input  8  loader byte
- ld_last  input  1  qualifies the final byte of the program
- ld_ready  output  1  block accepts a byte this cycle
- ld_done  output  1  one-cycle pulse when the load completes
- ld_err  output  1  sticky; program exceeded memory depth
- par_err  output  1  parity mismatch on fetched word (feature only, else 0)

Behaviour:
- Reset values, taken on clk edge while rst=1:
  - instr=NOP_WORD, instr_valid=0, ld_ready=0, ld_done=0, ld_err=0, par_err=0.
  - byte_cnt=0, word_cnt=0.
  - State = IDLE, or RUN if BOOT_RUN=1.
  - Memory contents are not cleared.
- State IDLE:
  - ld_ready=0, instr=NOP_WORD, instr_valid=0.
  - ld_start → LOAD; clear byte_cnt, word_cnt, ld_err.
- State LOAD:
  - ld_ready=1; accept a byte when ld_valid=1.
  - Assembly is little-endian: byte0 → bits[7:0], byte1 → [15:8], byte2 → [23:16], byte3[5:0] → [29:24]. byte3[7:6] is discarded.
  - After byte3 is accepted, write the word to mem[word_cnt] on the same edge, then word_cnt+1 and byte_cnt wraps to 0.
  - ld_last with a byte:
    - If mid-word, the remaining bytes are zero and the word is written on that edge.
    - Next state RUN; ld_done=1 for exactly one cycle.
  - word_cnt ≥ 2**ADDR_W at write time: the write is dropped and ld_err=1. Acceptance continues until ld_last.
  - ld_start during LOAD is ignored.
  - instr=NOP_WORD, instr_valid=0 throughout LOAD.
- State RUN:
  - ld_ready=0.
  - Each edge: instr ← mem[pc word index]; instr_valid ← 1. Latency is 1 cycle, and the first valid word appears one cycle after RUN is entered.
  - pc bits above ADDR_W+1 nonzero: instr ← NOP_WORD, instr_valid ← 1.
  - ld_start → LOAD. On that same edge instr ← NOP_WORD and instr_valid ← 0.
- Simultaneous events:
  - rst overrides everything.
  - ld_valid without ld_ready is ignored and the byte is not consumed.
  - ld_last with ld_valid=0 is ignored.
- Reset mid-load: FSM returns to IDLE. Words already written stay in memory; the partial word is lost.

Optional Feature:
- Macro IMEM_PARITY_EN.
- Defined:
  - Each word stores an extra even-parity bit computed at write.
  - On RUN reads, par_err is registered alongside instr; it is 1 when the stored parity ≠ the recomputed parity and 0 otherwise. NOP_WORD returns give par_err=0.
- Undefined: no parity storage, and par_err is tied to 0.

Test Plan:
- Reset, then ld_start and bytes 0F,00,00,22 with ld_last on the last byte → mem[0]=30'h2200000F; ld_done high one cycle; the next cycle instr_valid=0, and with pc=0 the following cycle instr=30'h2200000F, instr_valid=1.
- Load two words (8 bytes: 0A,00,00,22, 03,00,00,11) → pc=0 returns 30'h2200000A and pc=4 returns 30'h11000003, each 1 cycle after pc is applied; pc=5 returns the same word as pc=4.
- Load 5 bytes 01,02,03,04,FF with ld_last on FF → mem[0]=30'h04030201, mem[1]=30'h000000FF, ld_err=0.
- ADDR_W=2, load 5 words → ld_err=1, mem[0..3] correct, the fifth word is not written, ld_done still pulses.
- In RUN, pulse ld_start → next cycle instr=NOP_WORD (30'h1C000000), instr_valid=0, ld_ready=1. Assert rst after 2 bytes → IDLE, ld_ready=0, earlier memory words intact.
- pc=32'h00010000 with ADDR_W=8 in RUN → instr=NOP_WORD, instr_valid=1. With IMEM_PARITY_EN defined, force a flipped bit in a stored word → par_err=1 on that fetch.
